// File: rtl/pma_rx_word_aligner_pkg.sv
// pma_rx_pkg: comma codes, symbol width, aligner states and saturating increment
package pma_rx_pkg;
  localparam int SYM_W = 10;
  localparam logic [SYM_W-1:0] K28P5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28P5_RDP = 10'b1100000101;
  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction
endpackage

// File: rtl/pma_rx_word_aligner_if.sv
// pma_rx_word_aligner_if: recovered-bit input and aligned-symbol output bundle (Disp_Err with RX_DISP_CHECK_EN)
interface pma_rx_word_aligner_if;
  import pma_rx_pkg::*;
  logic Ser_in;
  logic RxPolarity;
  logic [SYM_W-1:0] Data_out;
  logic Data_Valid;
  logic Comma_Det;
  logic Symbol_Lock;
`ifdef RX_DISP_CHECK_EN
  logic Disp_Err;
  modport master(output Ser_in, RxPolarity, input Data_out, Data_Valid, Comma_Det, Symbol_Lock, Disp_Err);
  modport slave(input Ser_in, RxPolarity, output Data_out, Data_Valid, Comma_Det, Symbol_Lock, Disp_Err);
`else
  modport master(output Ser_in, RxPolarity, input Data_out, Data_Valid, Comma_Det, Symbol_Lock);
  modport slave(input Ser_in, RxPolarity, output Data_out, Data_Valid, Comma_Det, Symbol_Lock);
`endif
endinterface

// File: rtl/pma_rx_word_aligner_comma_detect.sv
// pma_comma_detect: hit[0] when w is K28.5 RD-, hit[1] when w is K28.5 RD+ (match = |hit, comma RD = hit[1])
module pma_comma_detect
  import pma_rx_pkg::*;
(
  input  logic [SYM_W-1:0] w,
  output logic [1:0]       hit
);
  assign hit = {w == K28P5_RDP, w == K28P5_RDN};
endmodule

// File: rtl/pma_rx_word_aligner.sv
// pma_rx_word_aligner: K28.5 comma word aligner for the recovered bit stream (optional RX_DISP_CHECK_EN)
module pma_rx_word_aligner
  import pma_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4
) (
  input logic Bit_Rate_Clk,
  input logic Rst,
  pma_rx_word_aligner_if.slave rx
);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] w_q, w_d, dout_q, dout_d;
  logic [3:0] ph_q, ph_d, good_q, good_d, bad_q, bad_d;
  logic dv_q, dv_d, cd_q, cd_d, lock_q, lock_d;
  logic [1:0] hit;
  logic match, boundary, emit, realign;
  pma_comma_detect u_det (.w(w_q), .hit(hit));
  assign match = |hit;
  assign boundary = ph_q == 4'd9;
  always_comb begin
    state_d = state_q;
    good_d = good_q;
    bad_d = bad_q;
    emit = 1'b0;
    realign = 1'b0;
    case (state_q)
      SEARCH: realign = match;
      SYNC: begin
        emit = boundary;
        bad_d = 4'd0;
        good_d = (match && boundary) ? sat_inc(good_q) : good_q;
        state_d = (match && boundary && sat_inc(good_q) >= 4'(LOCK_CNT)) ? LOCKED : SYNC;
        realign = match && !boundary;
      end
      LOCKED: begin
        emit = boundary;
        bad_d = (match && boundary) ? 4'd0 : match ? sat_inc(bad_q) : bad_q;
        realign = match && !boundary && sat_inc(bad_q) >= 4'(UNLOCK_CNT);
      end
      default: state_d = SEARCH;
    endcase
    if (realign) begin
      emit = 1'b1;
      good_d = 4'd1;
      bad_d = 4'd0;
      state_d = (LOCK_CNT == 1) ? LOCKED : SYNC;
    end
    w_d = {w_q[DATA_WIDTH-2:0], rx.Ser_in ^ rx.RxPolarity};
    ph_d = (realign || boundary) ? 4'd0 : ph_q + 4'd1;
    dout_d = emit ? w_q : dout_q;
    dv_d = emit;
    cd_d = emit && match;
    lock_d = state_d == LOCKED;
  end
  always_ff @(posedge Bit_Rate_Clk) begin
    if (Rst) begin
      state_q <= SEARCH;
      w_q <= '0;
      dout_q <= '0;
      ph_q <= 4'd0;
      good_q <= 4'd0;
      bad_q <= 4'd0;
      dv_q <= 1'b0;
      cd_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      dout_q <= dout_d;
      ph_q <= ph_d;
      good_q <= good_d;
      bad_q <= bad_d;
      dv_q <= dv_d;
      cd_q <= cd_d;
      lock_q <= lock_d;
    end
  end
  assign rx.Data_out = dout_q;
  assign rx.Data_Valid = dv_q;
  assign rx.Comma_Det = cd_q;
  assign rx.Symbol_Lock = lock_q;
`ifdef RX_DISP_CHECK_EN
  logic rd_q, rd_d, de_q, de_d, rd_in;
  logic [3:0] ones;
  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < DATA_WIDTH; i++) ones = ones + 4'(w_q[i]);
    rd_in = realign ? hit[1] : rd_q;
    de_d = emit && !(ones == 4'd5 || (ones == 4'd6 && !rd_in) || (ones == 4'd4 && rd_in));
    rd_d = !emit ? rd_q : (ones > 4'd5) ? 1'b1 : (ones < 4'd5) ? 1'b0 : rd_in;
  end
  always_ff @(posedge Bit_Rate_Clk) begin
    if (Rst) begin
      rd_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      de_q <= de_d;
    end
  end
  assign rx.Disp_Err = de_q;
`endif
endmodule

// File: tb/tb_pma_rx_word_aligner.sv
// tb_pma_rx_word_aligner: table-driven comma acquisition, slip, polarity and reset checks
module tb_pma_rx_word_aligner;
  import pma_rx_pkg::*;
  typedef struct {
    logic [9:0] sym;
    int         nb;
    logic       pol;
    logic       dv;
    logic [9:0] data;
    logic       cd;
    logic       lk;
    logic       chk_de;
    logic       de;
  } vec_t;
  localparam logic [9:0] KN = 10'h0FA;
  localparam logic [9:0] KP = 10'h305;
  localparam logic [9:0] DD = 10'h2AA;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int stray = 0;
  int hold_bad = 0;
  logic [9:0] last_data = '0;
  vec_t pend;
  string pend_name;
  bit have_pend = 0;
  vec_t q[$];
  pma_rx_word_aligner_if bus();
  pma_rx_word_aligner dut (.Bit_Rate_Clk(clk), .Rst(rst), .rx(bus));
  always #5 clk = ~clk;
  function automatic void add(input logic [9:0] sym, input int nb, input logic pol, input logic dv,
                              input logic [9:0] data, input logic cd, input logic lk,
                              input logic chk_de = 1'b0, input logic de = 1'b0);
    q.push_back('{sym, nb, pol, dv, data, cd, lk, chk_de, de});
  endfunction
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input logic b);
    bus.Ser_in = b;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_check();
    if (bus.Data_Valid !== 1'b0) stray++;
    if (bus.Data_out !== last_data) hold_bad++;
  endtask
  task automatic check_pend();
    chk({pend_name, ".valid"}, 10'(bus.Data_Valid), 10'(pend.dv));
    if (pend.dv) begin
      chk({pend_name, ".data"}, bus.Data_out, pend.data);
      chk({pend_name, ".comma"}, 10'(bus.Comma_Det), 10'(pend.cd));
      last_data = pend.data;
    end else if (bus.Data_out !== last_data) hold_bad++;
    chk({pend_name, ".lock"}, 10'(bus.Symbol_Lock), 10'(pend.lk));
`ifdef RX_DISP_CHECK_EN
    if (pend.chk_de) chk({pend_name, ".disp_err"}, 10'(bus.Disp_Err), 10'(pend.de));
`endif
    have_pend = 0;
  endtask
  task automatic run(input string tag);
    foreach (q[i]) begin
      bus.RxPolarity = q[i].pol;
      for (int b = q[i].nb - 1; b >= 0; b--) begin
        tick(q[i].sym[b]);
        if (have_pend) check_pend();
        else idle_check();
      end
      pend = q[i];
      pend_name = $sformatf("%s%0d", tag, i);
      have_pend = 1;
    end
    q.delete();
  endtask
  task automatic flush();
    tick(1'b0);
    check_pend();
  endtask
  task automatic check_zero(input string name);
    chk({name, ".valid"}, 10'(bus.Data_Valid), 10'd0);
    chk({name, ".data"}, bus.Data_out, 10'd0);
    chk({name, ".comma"}, 10'(bus.Comma_Det), 10'd0);
    chk({name, ".lock"}, 10'(bus.Symbol_Lock), 10'd0);
`ifdef RX_DISP_CHECK_EN
    chk({name, ".disp_err"}, 10'(bus.Disp_Err), 10'd0);
`endif
    last_data = '0;
  endtask
  initial begin
    bus.Ser_in = 1'b0;
    bus.RxPolarity = 1'b0;
    rst = 1'b1;
    repeat (3) tick(1'b0);
    check_zero("reset");
    rst = 1'b0;
    add(10'b10110, 5, 0, 0, 10'h0, 0, 0);
    add(KN, 10, 0, 1, KN, 1, 0);
    add(DD, 10, 0, 1, DD, 0, 0);
    add(KN, 10, 0, 1, KN, 1, 0);
    add(DD, 10, 0, 1, DD, 0, 0);
    add(KN, 10, 0, 1, KN, 1, 1);
    add(DD, 10, 0, 1, DD, 0, 1);
    add(KN, 10, 0, 1, KN, 1, 1);
    add(DD, 10, 0, 1, DD, 0, 1);
    run("acq");
    add(10'h29F, 10, 0, 1, 10'h29F, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add(10'h155, 10, 0, 1, 10'h155, 0, 1);
      add(10'h11F, 10, 0, 1, 10'h11F, 0, 1);
    end
    add(10'b010, 3, 0, 1, KN, 1, 0);
    add(DD, 10, 0, 1, DD, 0, 0);
    add(KN, 10, 0, 1, KN, 1, 0);
    add(DD, 10, 0, 1, DD, 0, 0);
    add(KN, 10, 0, 1, KN, 1, 1);
    add(DD, 10, 0, 1, DD, 0, 1);
    run("slip");
    flush();
    rst = 1'b1;
    tick(1'b0);
    check_zero("midrst");
    rst = 1'b0;
    add(DD, 10, 0, 0, 10'h0, 0, 0);
    add(DD, 10, 0, 0, 10'h0, 0, 0);
    add(KN, 10, 0, 1, KN, 1, 0, 1, 0);
    add(DD, 10, 0, 1, DD, 0, 0, 1, 0);
    add(KN, 10, 0, 1, KN, 1, 0, 1, 1);
    add(DD, 10, 0, 1, DD, 0, 0, 1, 0);
    add(KN, 10, 0, 1, KN, 1, 1);
    run("reacq");
    flush();
    rst = 1'b1;
    tick(1'b0);
    check_zero("polrst");
    rst = 1'b0;
    add(10'b01001, 5, 1, 0, 10'h0, 0, 0);
    add(KN, 10, 1, 1, KP, 1, 0);
    add(10'h155, 10, 1, 1, DD, 0, 0);
    add(KN, 10, 1, 1, KP, 1, 0);
    add(10'h155, 10, 1, 1, DD, 0, 0);
    add(KN, 10, 1, 1, KP, 1, 1);
    add(10'h155, 10, 1, 1, DD, 0, 1);
    run("pol");
    flush();
    chk("stray_strobes", 10'(stray), 10'd0);
    chk("data_hold", 10'(hold_bad), 10'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
